// File: rtl/anaio_seq_pkg.sv
// Shared definitions for the analog channel sequencer.
//   state_e       : sequencer FSM states
//   NUM_CHAN      : number of analog channels behind the switch matrix
//   CNT_W         : width of the break/settle interval counter
//   chan_onehot() : channel index -> switch-enable pattern
package anaio_seq_pkg;

  localparam int unsigned NUM_CHAN = 4;
  localparam int unsigned CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    MAKE,
    SETTLE,
    FIN
  } state_e;

  function automatic logic [NUM_CHAN-1:0] chan_onehot(input logic [1:0] ch);
    chan_onehot = NUM_CHAN'(1) << ch;
  endfunction

endpackage

// File: rtl/anaio_seq_timer.sv
// Interval timer for the sequencer's break and settle phases.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : load load_val_i into the counter (wins over dec_i)
//   load_val_i    : interval length in cycles
//   dec_i         : count down one step (saturates at zero)
//   expired_o     : current cycle is the last cycle of the loaded interval
module anaio_seq_timer
  import anaio_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load of N means N cycles in the phase; the count still reads 1 on the
  // final one, so the owner leaves the phase on that edge.
  assign expired_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/anaio_chan_sequencer.sv
// Break-before-make sequencer for a 4-way analog input switch.
// Optional feature macro: ANAIO_SEQ_ESD_CLAMP_EN adds esd_clamp output.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (accepted only when idle)
//   req_off             : 1 = disconnect everything, 0 = connect req_chan
//   req_chan            : channel to connect
//   sw_en               : switch enables, one-hot or zero
//   cur_chan            : connected channel, meaningful while connected=1
//   connected           : a channel is switched in and settled
//   busy                : sequence in progress
//   done                : one-cycle pulse at sequence end
//   esd_clamp           : (macro only) high while in the break gap
module anaio_chan_sequencer
  import anaio_seq_pkg::*;
#(
  parameter int unsigned BBM_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_off,
  input  logic [1:0] req_chan,
  output logic [3:0] sw_en,
  output logic [1:0] cur_chan,
  output logic       connected,
  output logic       busy,
`ifdef ANAIO_SEQ_ESD_CLAMP_EN
  output logic       done,
  output logic       esd_clamp
`else
  output logic       done
`endif
);

  localparam logic [CNT_W-1:0] BBM_V    = CNT_W'(BBM_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic                off_q, off_d;
  logic [1:0]          chan_q, chan_d;
  logic [NUM_CHAN-1:0] sw_en_q, sw_en_d;
  logic [1:0]          cur_chan_q, cur_chan_d;
  logic                connected_q, connected_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_exp;

  anaio_seq_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    chan_d      = chan_q;
    sw_en_d     = sw_en_q;
    cur_chan_d  = cur_chan_q;
    connected_d = connected_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d  = req_off;
          chan_d = req_chan;
          // Re-selecting the live channel skips the switch sequence entirely.
          if (!req_off && connected_q && (req_chan == cur_chan_q)) begin
            state_d = FIN;
          end else begin
            state_d     = BREAK;
            sw_en_d     = '0;
            connected_d = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = BBM_V;
          end
        end
      end
      BREAK: begin
        tmr_dec = 1'b1;
        if (tmr_exp) begin
          if (!off_q) begin
            // Enables change on the edge into MAKE so they are visible in MAKE.
            state_d    = MAKE;
            sw_en_d    = chan_onehot(chan_q);
            cur_chan_d = chan_q;
          end else begin
            state_d = FIN;
          end
        end
      end
      MAKE: begin
        state_d  = SETTLE;
        tmr_load = 1'b1;
        tmr_val  = SETTLE_V;
      end
      SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_exp) begin
          state_d     = FIN;
          connected_d = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= 1'b0;
      chan_q      <= '0;
      sw_en_q     <= '0;
      cur_chan_q  <= '0;
      connected_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      chan_q      <= chan_d;
      sw_en_q     <= sw_en_d;
      cur_chan_q  <= cur_chan_d;
      connected_q <= connected_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign sw_en     = sw_en_q;
  assign cur_chan  = cur_chan_q;
  assign connected = connected_q;

`ifdef ANAIO_SEQ_ESD_CLAMP_EN
  assign esd_clamp = (state_q == BREAK);
`endif

endmodule

// File: tb/tb_anaio_chan_sequencer.sv
module tb_anaio_chan_sequencer;

  localparam int BBM = 4;
  localparam int SET = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_off = 1'b0;
  logic [1:0] req_chan = 2'd0;
  logic       req_ready, connected, busy, done;
  logic [3:0] sw_en;
  logic [1:0] cur_chan;
`ifdef ANAIO_SEQ_ESD_CLAMP_EN
  logic       esd_clamp;
`endif

  always #5 clk = ~clk;

  anaio_chan_sequencer #(
    .BBM_CYCLES    (BBM),
    .SETTLE_CYCLES (SET)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_off   (req_off),
    .req_chan  (req_chan),
    .sw_en     (sw_en),
    .cur_chan  (cur_chan),
    .connected (connected),
    .busy      (busy),
`ifdef ANAIO_SEQ_ESD_CLAMP_EN
    .done      (done),
    .esd_clamp (esd_clamp)
`else
    .done      (done)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-request output schedule ----------
  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       conn;
    logic       esd;
    logic [3:0] sw;
    logic [1:0] ch;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  bit         chk_en = 1'b0;
  bit         m_conn = 1'b0;
  logic [1:0] m_ch = 2'd0;
  logic [3:0] m_sw = 4'd0;

  function automatic exp_t mk(input logic rdy, input logic bsy, input logic dn,
                              input logic cn, input logic es,
                              input logic [3:0] s, input logic [1:0] c);
    exp_t r;
    r.ready = rdy; r.busy = bsy; r.done = dn; r.conn = cn; r.esd = es;
    r.sw = s; r.ch = c;
    return r;
  endfunction

  // e holds what the outputs must show during the cycle that starts at this edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_conn = 1'b0;
      m_ch   = 2'd0;
      m_sw   = 4'd0;
      chk_en = 1'b1;
      e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    end else if (q.size() != 0) begin
      e = q.pop_front();
    end else if (e.ready === 1'b1 && req_valid) begin
      if (!req_off && m_conn && req_chan == m_ch) begin
        q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_sw, m_ch));
      end else begin
        for (int i = 0; i < BBM; i++) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, m_ch));
        if (!req_off) begin
          m_ch = req_chan;
          m_sw = 4'b0001 << req_chan;
          for (int i = 0; i < SET + 1; i++) q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, m_sw, m_ch));
          q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, m_sw, m_ch));
          m_conn = 1'b1;
        end else begin
          q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, m_ch));
          m_conn = 1'b0;
          m_sw   = 4'd0;
        end
      end
      e = q.pop_front();
    end else begin
      e = mk(1'b1, 1'b0, 1'b0, m_conn, 1'b0, m_sw, m_ch);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [3:0] last_nz = 4'd0;
  int         zrun = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", req_ready, e.ready);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("connected", connected, e.conn);
      chk("sw_en", sw_en, e.sw);
      if (e.conn) chk("cur_chan", cur_chan, e.ch);
`ifdef ANAIO_SEQ_ESD_CLAMP_EN
      chk("esd_clamp", esd_clamp, e.esd);
`endif
      chk("sw_onehot", $countones(sw_en) <= 1, 1);
      if (sw_en == 4'd0) begin
        zrun++;
      end else begin
        if (last_nz != 4'd0 && sw_en != last_nz) chk("bbm_gap", zrun >= BBM, 1);
        last_nz = sw_en;
        zrun = 0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", req_ready, 1);
  endtask

  // Returns #1 after the accept edge; inputs are scrambled to prove latching.
  task automatic send(input logic off, input logic [1:0] ch);
    @(negedge clk);
    req_valid = 1'b1;
    req_off   = off;
    req_chan  = ch;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_off   = 1'($urandom);
    req_chan  = 2'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_zero(output int z);
    z = 0;
    while (sw_en == 4'd0 && z < 50) begin
      z++;
      step();
    end
  endtask

  task automatic count_to_done(output int d);
    d = 0;
    while (!done && d < 100) begin
      step();
      d++;
    end
  endtask

  initial begin
    int z, d;
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sw_en", sw_en, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_conn", connected, 0);
    chk("rst_done", done, 0);
    chk("rst_cur", cur_chan, 0);
    rst = 1'b0;

    // connect chan 2 from reset
    wait_idle();
    send(1'b0, 2'd2);
    count_zero(z);
    chk("c2_zero_cycles", z, 4);
    chk("c2_sw_en", sw_en, 4'b0100);
    count_to_done(d);
    chk("c2_settle_cycles", d, 17);
    chk("c2_conn", connected, 1);
    chk("c2_cur", cur_chan, 2);

    // switch chan 2 -> chan 0
    wait_idle();
    chk("c0_before", sw_en, 4'b0100);
    send(1'b0, 2'd0);
    count_zero(z);
    chk("c0_zero_cycles", z, 4);
    chk("c0_sw_en", sw_en, 4'b0001);
    count_to_done(d);
    chk("c0_cur", cur_chan, 0);

    // same-channel request on chan 1
    wait_idle();
    send(1'b0, 2'd1);
    count_to_done(d);
    wait_idle();
    send(1'b0, 2'd1);
    chk("same_done", done, 1);
    chk("same_sw_en", sw_en, 4'b0010);
    chk("same_conn", connected, 1);
    step();
    chk("same_idle", busy, 0);
    chk("same_sw_after", sw_en, 4'b0010);

    // disconnect while connected
    wait_idle();
    send(1'b1, 2'd3);
    chk("off_sw_en", sw_en, 4'b0000);
    chk("off_conn", connected, 0);
    count_to_done(d);
    chk("off_done_delay", d, 4);
    chk("off_conn_done", connected, 0);

    // disconnect while already disconnected still runs a full sequence
    wait_idle();
    send(1'b1, 2'd0);
    chk("off2_busy", busy, 1);
    count_to_done(d);
    chk("off2_done_delay", d, 4);

    // reset during SETTLE
    wait_idle();
    send(1'b0, 2'd3);
    repeat (6) step();
    chk("mid_busy", busy, 1);
    chk("mid_sw_en", sw_en, 4'b1000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_sw", sw_en, 4'b0000);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_conn", connected, 0);
    chk("mid_rst_done", done, 0);
    step();
    chk("mid_rst_nodone", done, 0);

`ifdef ANAIO_SEQ_ESD_CLAMP_EN
    // clamp width per switch sequence
    wait_idle();
    send(1'b0, 2'd1);
    z = 0;
    d = 0;
    while (!done && d < 100) begin
      if (esd_clamp) z++;
      step();
      d++;
    end
    chk("esd_cycles", z, BBM);
`endif

    // randomized traffic, inputs toggling freely while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_off   = ($urandom_range(0, 3) == 0);
      req_chan  = 2'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
